// File: rtl/picorv32_axi_mem.sv
// AXI4-Lite slave RAM + console byte port for picorv32_axi; reads 1 cycle, writes commit 1 cycle after AW+W, response held until bready/rready.
// Out-of-range accesses complete with a sticky error; `define AXI_MEM_STALL_EN adds LFSR-driven ready/response stalls.
module picorv32_axi_mem #(
    parameter int          MEM_WORDS    = 16384,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic [7:0]  cons_data,
    output logic        oob_err,
    output logic [31:0] oob_addr
);
    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {W_IDLE, W_CONS, W_RESP} wstate_t;

    logic [31:0] mem [MEM_WORDS];

    wstate_t     fsm, fsm_nxt;
    logic        live;
    logic        aw_lat, w_lat, r_pend;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, ar_hs, r_hs;
    logic        aw_in_range, ar_in_range;
    logic        wr_ram, wr_oob, cons_load, b_done;
    logic        stall_ar, stall_aw, stall_w, stall_resp;
    logic        unused_prot;

`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall_ar   = lfsr[0];
    assign stall_aw   = lfsr[1];
    assign stall_w    = lfsr[2];
    assign stall_resp = lfsr[3];
`else
    assign stall_ar   = 1'b0;
    assign stall_aw   = 1'b0;
    assign stall_w    = 1'b0;
    assign stall_resp = 1'b0;
`endif

    assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

    assign aw_in_range = {1'b0, aw_addr_q} < MEM_BYTES;
    assign ar_in_range = {1'b0, mem_axi_araddr} < MEM_BYTES;

    // live keeps every ready low while reset is asserted
    assign mem_axi_awready = live && !aw_lat && (fsm == W_IDLE) && !stall_aw;
    assign mem_axi_wready  = live && !w_lat  && (fsm == W_IDLE) && !stall_w;
    assign mem_axi_arready = live && !r_pend && !stall_ar;
    assign mem_axi_rvalid  = r_pend && !stall_resp;
    assign mem_axi_bvalid  = (fsm == W_RESP) && !stall_resp;
    assign cons_valid      = (fsm == W_CONS);

    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs  = mem_axi_wvalid  && mem_axi_wready;
    assign ar_hs = mem_axi_arvalid && mem_axi_arready;
    assign r_hs  = mem_axi_rvalid  && mem_axi_rready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fsm <= W_IDLE;
        else         fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        wr_ram    = 1'b0;
        wr_oob    = 1'b0;
        cons_load = 1'b0;
        b_done    = 1'b0;
        case (fsm)
            W_IDLE: begin
                if (aw_lat && w_lat) begin
                    if (aw_in_range) begin
                        wr_ram  = 1'b1;
                        fsm_nxt = W_RESP;
                    end else if (aw_addr_q == CONSOLE_ADDR) begin
                        cons_load = 1'b1;
                        fsm_nxt   = W_CONS;
                    end else begin
                        wr_oob  = 1'b1;
                        fsm_nxt = W_RESP;
                    end
                end
            end
            W_CONS: if (cons_ready) fsm_nxt = W_RESP;
            W_RESP: begin
                if (mem_axi_bvalid && mem_axi_bready) begin
                    b_done  = 1'b1;
                    fsm_nxt = W_IDLE;
                end
            end
            default: fsm_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live          <= 1'b0;
            aw_lat        <= 1'b0;
            aw_addr_q     <= '0;
            w_lat         <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            r_pend        <= 1'b0;
            mem_axi_rdata <= '0;
            cons_data     <= '0;
            oob_err       <= 1'b0;
            oob_addr      <= '0;
        end else begin
            live <= 1'b1;
            if (b_done) begin
                aw_lat <= 1'b0;
                w_lat  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_lat    <= 1'b1;
                    aw_addr_q <= mem_axi_awaddr;
                end
                if (w_hs) begin
                    w_lat    <= 1'b1;
                    w_data_q <= mem_axi_wdata;
                    w_strb_q <= mem_axi_wstrb;
                end
            end
            if (ar_hs) begin
                r_pend        <= 1'b1;
                mem_axi_rdata <= ar_in_range ? mem[mem_axi_araddr[IDX_W+1:2]] : '0;
            end else if (r_hs) begin
                r_pend <= 1'b0;
            end
            if (cons_load) cons_data <= w_data_q[7:0];
            // first error wins; a same-edge write error beats the read
            if (!oob_err) begin
                if (wr_oob) begin
                    oob_err  <= 1'b1;
                    oob_addr <= aw_addr_q;
                end else if (ar_hs && !ar_in_range) begin
                    oob_err  <= 1'b1;
                    oob_addr <= mem_axi_araddr;
                end
            end
        end
    end

    // RAM has no reset so its contents survive resetn
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) mem[aw_addr_q[IDX_W+1:2]][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_picorv32_axi_mem.sv
// Randomized bench for picorv32_axi_mem against a word-array reference model.
`timescale 1ns/1ps
module tb_picorv32_axi_mem;
    localparam int          TMO      = 200;
    localparam logic [31:0] CONS     = 32'h1000_0000;
    localparam logic [31:0] MEM_TOP  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata, oob_addr;
    logic [3:0]  wstrb;
    logic        cons_valid, cons_ready, oob_err;
    logic [7:0]  cons_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    picorv32_axi_mem dut (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(3'b000),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
        .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
        .mem_axi_arprot(3'b000),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
        .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_data(cons_data),
        .oob_err(oob_err), .oob_addr(oob_addr)
    );

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awvalid = 1'b1; awaddr = a;
        while (!awready && n < TMO) begin step(1); n++; end
        checks++;
        if (awready !== 1'b1) begin
            failures++; $display("FAIL aw_handshake: awready=%b required 1 within %0d cycles", awready, TMO);
        end
        step(1); awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wvalid = 1'b1; wdata = d; wstrb = s;
        while (!wready && n < TMO) begin step(1); n++; end
        checks++;
        if (wready !== 1'b1) begin
            failures++; $display("FAIL w_handshake: wready=%b required 1 within %0d cycles", wready, TMO);
        end
        step(1); wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        arvalid = 1'b1; araddr = a;
        while (!arready && n < TMO) begin step(1); n++; end
        checks++;
        if (arready !== 1'b1) begin
            failures++; $display("FAIL ar_handshake: arready=%b required 1 within %0d cycles", arready, TMO);
        end
        step(1); arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < TMO) begin step(1); n++; end
        checks++;
        if (bvalid !== 1'b1) begin
            failures++; $display("FAIL b_response: bvalid=%b required 1 within %0d cycles", bvalid, TMO);
        end
        step(1); bready = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < TMO) begin step(1); n++; end
        checks++;
        if (rvalid !== 1'b1) begin
            failures++; $display("FAIL r_response: rvalid=%b required 1 within %0d cycles", rvalid, TMO);
        end
        d = rdata;
        step(1); rready = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b();
        if (a < MEM_TOP)
            model[a >> 2] = merge(model.exists(a >> 2) ? model[a >> 2] : 32'h0, d, s);
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        send_ar(a);
        get_r(d);
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++; $display("FAIL reset_readies: got %b required 000", {awready, wready, arready});
        end
        checks++;
        if ({rvalid, bvalid, cons_valid, oob_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_valids: got %b required 0000", {rvalid, bvalid, cons_valid, oob_err});
        end
        checks++;
        if ({rdata, oob_addr, cons_data} !== 72'h0) begin
            failures++; $display("FAIL reset_data: rdata=%h oob_addr=%h cons_data=%h required all 0", rdata, oob_addr, cons_data);
        end
        resetn = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        logic [31:0] d;
        write_word(32'h100, 32'hDEAD_BEEF, 4'hF);
        send_ar(32'h100);
        checks++;
        if (rvalid !== 1'b1) begin
            failures++; $display("FAIL read_latency: rvalid=%b one cycle after AR, required 1", rvalid);
        end
        get_r(d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL basic_read: got %h required %h", d, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        write_word(32'h100, 32'h0000_00AA, 4'b0001);
        read_word(32'h100, d);
        checks++;
        if (d !== 32'hDEAD_BEAA) begin
            failures++; $display("FAIL strobe_byte0: got %h required DEADBEAA", d);
        end
        write_word(32'h100, 32'hDEAD_BEEF, 4'hF);
        send_w(32'h0000_00AA, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bvalid, wready, awready} !== 3'b001) begin
                failures++; $display("FAIL w_first_wait: {bvalid,wready,awready}=%b required 001", {bvalid, wready, awready});
            end
            step(1);
        end
        send_aw(32'h100);
        wait_b();
        model[32'h40] = merge(model[32'h40], 32'h0000_00AA, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bvalid !== 1'b0) begin
                failures++; $display("FAIL w_first_single_b: extra bvalid=%b required 0", bvalid);
            end
            step(1);
        end
        read_word(32'h100, d);
        checks++;
        if (d !== model[32'h40]) begin
            failures++; $display("FAIL w_first_read: got %h required %h", d, model[32'h40]);
        end
    endtask

    task automatic test_console();
        cons_ready = 1'b0;
        bready = 1'b1;
        fork
            send_aw(CONS);
            send_w(32'h0000_0041, 4'b0001);
        join
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if ({cons_valid, cons_data, bvalid} !== {1'b1, 8'h41, 1'b0}) begin
                failures++; $display("FAIL console_hold: cons_valid=%b cons_data=%h bvalid=%b required 1 41 0", cons_valid, cons_data, bvalid);
            end
        end
        cons_ready = 1'b1;
        step(1);
        cons_ready = 1'b0;
        checks++;
        if ({cons_valid, bvalid} !== 2'b01) begin
            failures++; $display("FAIL console_to_b: cons_valid=%b bvalid=%b required 0 1", cons_valid, bvalid);
        end
        step(1);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++; $display("FAIL console_b_done: bvalid=%b required 0", bvalid);
        end
    endtask

    task automatic test_read_before_write();
        logic [31:0] d;
        write_word(32'h180, 32'h1111_1111, 4'hF);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++; $display("FAIL rbw_idle: readies=%b required 111", {awready, wready, arready});
        end
        awvalid = 1'b1; awaddr = 32'h180; wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF;
        araddr = 32'h180;
        step(1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        step(1);
        arvalid = 1'b0;
        checks++;
        if ({rvalid, bvalid, rdata} !== {2'b11, 32'h1111_1111}) begin
            failures++; $display("FAIL read_before_write: rvalid=%b bvalid=%b rdata=%h required 1 1 11111111", rvalid, bvalid, rdata);
        end
        rready = 1'b1; bready = 1'b1;
        step(1);
        rready = 1'b0; bready = 1'b0;
        model[32'h180 >> 2] = 32'h2222_2222;
        read_word(32'h180, d);
        checks++;
        if (d !== 32'h2222_2222) begin
            failures++; $display("FAIL rbw_new_data: got %h required 22222222", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        bready = 1'b0;
        fork
            send_aw(32'h300);
            send_w(32'h5A5A_0303, 4'hF);
        join
        model[32'h300 >> 2] = 32'h5A5A_0303;
        step(1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                failures++; $display("FAIL b_backpressure: {bvalid,awready,wready}=%b required 100", {bvalid, awready, wready});
            end
            step(1);
        end
        wait_b();
        rready = 1'b0;
        send_ar(32'h300);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rvalid, arready, rdata} !== {2'b10, 32'h5A5A_0303}) begin
                failures++; $display("FAIL r_backpressure: rvalid=%b arready=%b rdata=%h required 1 0 5a5a0303", rvalid, arready, rdata);
            end
            step(1);
        end
        get_r(d);
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        write_word(32'h140, 32'hCAFE_F00D, 4'hF);
        araddr = 32'h140; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (rvalid) begin
                cnt++;
                checks++;
                if (rdata !== 32'hCAFE_F00D) begin
                    failures++; $display("FAIL b2b_data: got %h required cafef00d", rdata);
                end
            end
        end
        arvalid = 1'b0; rready = 1'b0;
        checks++;
        if (cnt != 4) begin
            failures++; $display("FAIL b2b_rate: %0d reads in 8 cycles, required 4", cnt);
        end
        step(1);
    endtask

    task automatic test_random();
        logic [31:0] a, d, got;
        logic [3:0]  s;
        int d1, d2;
        for (int i = 0; i < 32; i++) write_word(32'h800 + 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            a = 32'h800 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
                fork
                    begin step(d1); send_aw(a); end
                    begin step(d2); send_w(d, s); end
                join
                step($urandom_range(0, 2));
                wait_b();
                model[a >> 2] = merge(model[a >> 2], d, s);
            end else begin
                send_ar(a);
                step($urandom_range(0, 2));
                get_r(got);
                checks++;
                if (got !== model[a >> 2]) begin
                    failures++; $display("FAIL random_read: addr=%h got %h required %h", a, got, model[a >> 2]);
                end
            end
        end
    endtask

    task automatic test_oob();
        logic [31:0] d;
        checks++;
        if (oob_err !== 1'b0) begin
            failures++; $display("FAIL oob_clear_before: oob_err=%b required 0", oob_err);
        end
        write_word(32'hFFFC, 32'h7777_8888, 4'hF);
        read_word(32'hFFFC, d);
        checks++;
        if ({d, oob_err} !== {32'h7777_8888, 1'b0}) begin
            failures++; $display("FAIL top_word: rdata=%h oob_err=%b required 77778888 0", d, oob_err);
        end
        read_word(MEM_TOP, d);
        checks++;
        if ({d, oob_err, oob_addr} !== {32'h0, 1'b1, MEM_TOP}) begin
            failures++; $display("FAIL oob_read: rdata=%h oob_err=%b oob_addr=%h required 0 1 00010000", d, oob_err, oob_addr);
        end
        read_word(CONS, d);
        checks++;
        if (d !== 32'h0) begin
            failures++; $display("FAIL console_read: rdata=%h required 0", d);
        end
        write_word(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if ({oob_err, oob_addr} !== {1'b1, MEM_TOP}) begin
            failures++; $display("FAIL oob_sticky: oob_err=%b oob_addr=%h required 1 00010000", oob_err, oob_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        write_word(32'h404, 32'h1234_5678, 4'hF);
        send_aw(32'h404);
        resetn = 1'b0;
        step(1);
        checks++;
        if ({awready, wready, arready, rvalid, bvalid, cons_valid, oob_err} !== 7'b0) begin
            failures++; $display("FAIL reset_mid_outputs: got %b required 0000000", {awready, wready, arready, rvalid, bvalid, cons_valid, oob_err});
        end
        step(1);
        resetn = 1'b1;
        step(1);
        write_word(32'h200, 32'h0BAD_CAFE, 4'hF);
        read_word(32'h404, d);
        checks++;
        if (d !== model[32'h404 >> 2]) begin
            failures++; $display("FAIL stale_aw: rdata=%h required %h", d, model[32'h404 >> 2]);
        end
        read_word(32'h200, d);
        checks++;
        if (d !== 32'h0BAD_CAFE) begin
            failures++; $display("FAIL fresh_write: rdata=%h required 0badcafe", d);
        end
        read_word(32'h100, d);
        checks++;
        if ({d, oob_err} !== {model[32'h100 >> 2], 1'b0}) begin
            failures++; $display("FAIL ram_kept: rdata=%h oob_err=%b required %h 0", d, oob_err, model[32'h100 >> 2]);
        end
    endtask

    initial begin
        resetn = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0; cons_ready = 1'b0;
        #2 resetn = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_console();
        test_read_before_write();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_oob();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
